// File: rtl/freq_meas_scheduler_pkg.sv
// Shared types and helpers for the multiplexed frequency-measurement scheduler:
// FSM encoding, default result width and channel-selection helper.
package freq_meas_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_CALC,
        ST_REPORT
    } state_e;

    localparam int                   DEF_CNT_W = 24;
    localparam logic [DEF_CNT_W-1:0] DEF_SAT   = '1;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } ch_pick_t;

    // Lowest set bit of mask at index >= from; from = 4 means no candidate remains.
    function automatic ch_pick_t next_set(input logic [3:0] mask, input logic [2:0] from);
        ch_pick_t pick;
        pick = '0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                pick.found = 1'b1;
                pick.idx   = 2'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/freq_edge_sync.sv
// Two-flop synchroniser for the selected measured signal followed by a
// rising-edge detector.
module freq_edge_sync (
    input  logic clk,
    input  logic res,
    input  logic sig,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: non-blocking assignments so each flop samples its pre-edge neighbour.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= sig;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/freq_meas_scheduler.sv
// Scans enabled channels through one gated edge counter, scales the count to Hz
// and hands each reading to the consumer over a valid/ready handshake.
module freq_meas_scheduler
    import freq_meas_scheduler_pkg::*;
#(
    parameter int GATE_CYCLES   = 500000,
    parameter int SCALE         = 20,
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             cont,
    input  logic [3:0]       ch_mask,
    input  logic [3:0]       sig_in,
    output logic             busy,
    output logic [1:0]       ch_sel,
    output logic [CNT_W-1:0] result,
    output logic [1:0]       result_ch,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow
);

    localparam int               GC_W   = $clog2(GATE_CYCLES + 1);
    localparam int               SC_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int               PROD_W = CNT_W + 32;
    localparam logic [CNT_W-1:0] SAT    = '1;

    state_e            state_q, state_d;
    logic [3:0]        mask_q, mask_d;
    logic [1:0]        ch_sel_q, ch_sel_d;
    logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [GC_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]  result_q, result_d;
    logic [1:0]        result_ch_q, result_ch_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;

    logic              rise;
    logic [PROD_W-1:0] prod;
    ch_pick_t          higher_pick;
    ch_pick_t          start_pick;

    freq_edge_sync u_sync (
        .clk  (clk),
        .res  (res),
        .sig  (sig_in[ch_sel_q]),
        .rise (rise)
    );

    assign prod        = PROD_W'(edge_cnt_q) * PROD_W'(SCALE);
    assign higher_pick = next_set(mask_q, {1'b0, ch_sel_q} + 3'd1);
    assign start_pick  = next_set(ch_mask, 3'd0);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            ch_sel_q     <= '0;
            settle_cnt_q <= '0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            result_q     <= '0;
            result_ch_q  <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            ch_sel_q     <= ch_sel_d;
            settle_cnt_q <= settle_cnt_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            result_q     <= result_d;
            result_ch_q  <= result_ch_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
        end
    end

    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        ch_sel_d     = ch_sel_q;
        settle_cnt_d = settle_cnt_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        result_d     = result_q;
        result_ch_d  = result_ch_q;
        valid_d      = valid_q;
        ovf_d        = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && start_pick.found) begin
                    mask_d       = ch_mask;
                    ch_sel_d     = start_pick.idx;
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SC_W'(SETTLE_CYCLES - 1)) begin
                    edge_cnt_d = '0;
                    gate_cnt_d = '0;
                    state_d    = ST_GATE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_GATE: begin
                if (rise && (edge_cnt_q != SAT)) begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                end
                if (gate_cnt_q == GC_W'(GATE_CYCLES - 1)) begin
                    state_d = ST_CALC;
                end else begin
                    gate_cnt_d = gate_cnt_q + 1'b1;
                end
            end
            ST_CALC: begin
                ovf_d       = |prod[PROD_W-1:CNT_W];
                result_d    = ovf_d ? SAT : prod[CNT_W-1:0];
                result_ch_d = ch_sel_q;
                valid_d     = 1'b1;
                state_d     = ST_REPORT;
            end
            ST_REPORT: begin
                if (result_ready) begin
                    valid_d      = 1'b0;
                    settle_cnt_d = '0;
                    if (higher_pick.found) begin
                        ch_sel_d = higher_pick.idx;
                        state_d  = ST_SETTLE;
                    end else if (cont) begin
                        // Scan wraps: the mask is re-sampled so enables can change between scans.
                        mask_d = ch_mask;
                        if (start_pick.found) begin
                            ch_sel_d = start_pick.idx;
                            state_d  = ST_SETTLE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy         = (state_q != ST_IDLE);
    assign ch_sel       = ch_sel_q;
    assign result       = result_q;
    assign result_ch    = result_ch_q;
    assign result_valid = valid_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Directed bench for freq_meas_scheduler: a 24-bit and an 8-bit instance share
// stimulus; expected readings are edges-per-gate * 20 computed by hand.
module tb_freq_meas_scheduler;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [3:0]  ch_mask = 4'b0000;
    logic [3:0]  sig_in = 4'b0000;
    logic        result_ready = 1'b1;

    logic        busy, busy8;
    logic [1:0]  ch_sel, ch_sel8;
    logic [23:0] result;
    logic [7:0]  result8;
    logic [1:0]  result_ch, result_ch8;
    logic        result_valid, result_valid8;
    logic        overflow, overflow8;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int per [4] = '{0, 0, 0, 0};
    int k;
    int errs;

    freq_meas_scheduler #(.GATE_CYCLES(100), .SCALE(20), .SETTLE_CYCLES(3), .CNT_W(24)) dut (
        .clk(clk), .res(res), .start(start), .cont(cont), .ch_mask(ch_mask), .sig_in(sig_in),
        .busy(busy), .ch_sel(ch_sel), .result(result), .result_ch(result_ch),
        .result_valid(result_valid), .result_ready(result_ready), .overflow(overflow)
    );

    freq_meas_scheduler #(.GATE_CYCLES(100), .SCALE(20), .SETTLE_CYCLES(3), .CNT_W(8)) dut8 (
        .clk(clk), .res(res), .start(start), .cont(cont), .ch_mask(ch_mask), .sig_in(sig_in),
        .busy(busy8), .ch_sel(ch_sel8), .result(result8), .result_ch(result_ch8),
        .result_valid(result_valid8), .result_ready(result_ready), .overflow(overflow8)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Channel i is a square wave of per[i] clk cycles (0 = held low).
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            sig_in[i] = (per[i] != 0) && ((cyc % per[i]) < (per[i] / 2));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        while (!result_valid && cnt < budget) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("valid_timeout", 32'(cnt < budget), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_ch_sel",   32'(ch_sel),       32'd0);
        check("rst_result",   32'(result),       32'd0);
        check("rst_res_ch",   32'(result_ch),    32'd0);
        check("rst_valid",    32'(result_valid), 32'd0);
        check("rst_overflow", 32'(overflow),     32'd0);
        @(negedge clk) res = 1'b0;

        // Single channel, period 10 -> 10 edges -> 200 Hz, valid in cycle 105
        per = '{10, 0, 0, 0};
        ch_mask = 4'b0001;
        result_ready = 1'b1;
        pulse_start();
        wait_valid(200, k);
        check("single_latency", 32'(k + 1), 32'd105);
        check("single_result",  32'(result),    32'd200);
        check("single_ch",      32'(result_ch), 32'd0);
        check("single_ovf",     32'(overflow),  32'd0);
        check("single_res8",    32'(result8),   32'd200);
        @(posedge clk); #1;
        check("single_valid_drop", 32'(result_valid), 32'd0);
        check("single_idle",       32'(busy),         32'd0);
        check("single_hold",       32'(result),       32'd200);

        // Scan order: ch1 (period 4 -> 500) then ch3 (period 20 -> 100)
        per = '{10, 4, 6, 20};
        ch_mask = 4'b1010;
        pulse_start();
        wait_valid(200, k);
        check("scan1_ch",     32'(result_ch), 32'd1);
        check("scan1_result", 32'(result),    32'd500);
        check("scan1_res8",   32'(result8),   32'd255);
        check("scan1_ovf8",   32'(overflow8), 32'd1);
        @(posedge clk); #1;
        wait_valid(200, k);
        check("scan2_ch",     32'(result_ch), 32'd3);
        check("scan2_result", 32'(result),    32'd100);
        errs = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (result_valid || busy) errs++;
        end
        check("scan_no_extra", 32'(errs), 32'd0);

        // Backpressure: ch0 result held for 50 cycles, ch1 must not start
        per = '{10, 4, 0, 0};
        ch_mask = 4'b0011;
        result_ready = 1'b0;
        pulse_start();
        wait_valid(200, k);
        check("bp_result", 32'(result),    32'd200);
        check("bp_ch",     32'(result_ch), 32'd0);
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (result !== 24'd200 || result_ch !== 2'd0 || overflow !== 1'b0 ||
                result_valid !== 1'b1 || ch_sel !== 2'd0 || busy !== 1'b1) errs++;
        end
        check("bp_stable", 32'(errs), 32'd0);
        @(negedge clk) result_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", 32'(result_valid), 32'd0);
        check("bp_next_ch",    32'(ch_sel),       32'd1);
        check("bp_busy",       32'(busy),         32'd1);
        wait_valid(200, k);
        check("bp2_ch",     32'(result_ch), 32'd1);
        check("bp2_result", 32'(result),    32'd500);
        @(posedge clk); #1;
        check("bp_idle", 32'(busy), 32'd0);

        // Saturation: toggle every cycle -> 50 edges -> 1000 Hz
        per = '{2, 0, 0, 0};
        ch_mask = 4'b0001;
        pulse_start();
        wait_valid(200, k);
        check("sat_res8",   32'(result8),   32'd255);
        check("sat_ovf8",   32'(overflow8), 32'd1);
        check("sat_result", 32'(result),    32'd1000);
        check("sat_ovf",    32'(overflow),  32'd0);
        @(posedge clk); #1;

        // Start with an empty mask is ignored
        ch_mask = 4'b0000;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        check("empty_start_busy", 32'(busy), 32'd0);

        // Start during GATE (with a wider mask) changes nothing
        per = '{10, 4, 0, 0};
        ch_mask = 4'b0001;
        pulse_start();
        repeat (20) @(negedge clk);
        start = 1'b1;
        ch_mask = 4'b1111;
        @(negedge clk);
        start = 1'b0;
        ch_mask = 4'b0001;
        wait_valid(200, k);
        check("ign_ch",     32'(result_ch), 32'd0);
        check("ign_result", 32'(result),    32'd200);
        @(posedge clk); #1;
        check("ign_idle", 32'(busy), 32'd0);

        // Reset during GATE discards the measurement
        pulse_start();
        repeat (30) @(negedge clk);
        res = 1'b1;
        #1;
        check("midrst_busy",   32'(busy),      32'd0);
        check("midrst_result", 32'(result),    32'd0);
        check("midrst_ch_sel", 32'(ch_sel),    32'd0);
        @(negedge clk) res = 1'b0;
        pulse_start();
        wait_valid(200, k);
        check("postrst_latency", 32'(k + 1), 32'd105);
        check("postrst_result",  32'(result), 32'd200);
        @(posedge clk); #1;

        // Continuous mode: clearing the mask mid-scan ends the scan at re-latch
        cont = 1'b1;
        ch_mask = 4'b0001;
        pulse_start();
        repeat (50) @(negedge clk);
        ch_mask = 4'b0000;
        wait_valid(200, k);
        check("cont_result", 32'(result),    32'd200);
        check("cont_ch",     32'(result_ch), 32'd0);
        @(posedge clk); #1;
        check("cont_idle", 32'(busy), 32'd0);
        cont = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
